// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: request record, tag/index types and
// the per-requester response state.
package mem_arbiter_pkg;

  localparam int MAX_PA_WIDTH   = 64;
  localparam int MAX_LINE_WIDTH = 1024;
  localparam int MAX_ID_WIDTH   = 8;

  typedef logic [MAX_ID_WIDTH-1:0] mem_id_t;
  typedef logic [MAX_ID_WIDTH-1:0] req_idx_t;

  typedef enum logic {
    REQ_IDLE,
    REQ_WAIT_RESP
  } req_state_e;

  // Sized for the widest configuration; instances zero-extend into it.
  typedef struct packed {
    logic                      write;
    logic [MAX_PA_WIDTH-1:0]   addr;
    logic [MAX_LINE_WIDTH-1:0] data;
  } mem_req_t;

  function automatic req_idx_t rr_next(input req_idx_t idx, input int n);
    return (int'(idx) == n - 1) ? '0 : req_idx_t'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping,
// returned as a one-hot grant.
module rr_arbiter #(
  parameter int N         = 2,
  parameter int PTR_WIDTH = 1
) (
  input  logic [N-1:0]         req,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [N-1:0]         grant
);

  logic found;

  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!found && req[wrap(int'(ptr) + off)]) begin
        grant[wrap(int'(ptr) + off)] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-way memory arbiter: round-robin request grant, registered memory request
// port, tagged read responses routed back combinationally, sticky error flag.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int PA_WIDTH   = 32,
  parameter int LINE_WIDTH = 256,
  parameter int ID_WIDTH   = 2,
  parameter int N_REQ      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 i_req_valid,
  input  logic [N_REQ-1:0]                 i_req_write,
  input  logic [N_REQ-1:0][PA_WIDTH-1:0]   i_req_addr,
  input  logic [N_REQ-1:0][LINE_WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]                 o_req_ready,
  output logic                             o_mem_enable,
  output logic                             o_mem_write,
  output logic [PA_WIDTH-1:0]              o_mem_addr,
  output logic [LINE_WIDTH-1:0]            o_mem_data,
  output logic [ID_WIDTH-1:0]              o_mem_id,
  input  logic                             i_mem_enable,
  input  logic [LINE_WIDTH-1:0]            i_mem_data,
  input  logic [ID_WIDTH-1:0]              i_mem_id,
  output logic [N_REQ-1:0]                 o_resp_valid,
  output logic [LINE_WIDTH-1:0]            o_resp_data,
  output logic                             o_err
);

  logic [N_REQ-1:0]      busy;
  logic [N_REQ-1:0]      eligible;
  logic [N_REQ-1:0]      grant;
  logic [N_REQ-1:0]      resp_hit;
  logic                  grant_any;
  req_idx_t              grant_idx;
  mem_req_t              sel_req;

  logic [ID_WIDTH-1:0]   rr_ptr_reg;
  logic                  mem_enable_reg;
  logic                  mem_write_reg;
  logic [PA_WIDTH-1:0]   mem_addr_reg;
  logic [LINE_WIDTH-1:0] mem_data_reg;
  logic [ID_WIDTH-1:0]   mem_id_reg;
  logic                  err_reg;

  // Nothing is granted or answered while reset is held.
  assign eligible = i_req_valid & ~busy & {N_REQ{~rst}};

  rr_arbiter #(
    .N         (N_REQ),
    .PTR_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req   (eligible),
    .ptr   (rr_ptr_reg),
    .grant (grant)
  );

  assign grant_any   = |grant;
  assign o_req_ready = grant;

  always_comb begin
    grant_idx = '0;
    sel_req   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_idx     = req_idx_t'(i);
        sel_req.write = i_req_write[i];
        sel_req.addr  = MAX_PA_WIDTH'(i_req_addr[i]);
        sel_req.data  = MAX_LINE_WIDTH'(i_req_data[i]);
      end
    end
  end

  // Per-requester response tracking: only reads wait for a tagged response.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    req_state_e state_reg;
    req_state_e state_next;

    assign busy[gi]     = (state_reg == REQ_WAIT_RESP);
    assign resp_hit[gi] = i_mem_enable & ~rst & busy[gi] &
                          (i_mem_id == ID_WIDTH'(gi));

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        REQ_IDLE:      if (grant[gi] && !i_req_write[gi]) state_next = REQ_WAIT_RESP;
        REQ_WAIT_RESP: if (resp_hit[gi]) state_next = REQ_IDLE;
        default:       state_next = REQ_IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= REQ_IDLE;
      else     state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg     <= '0;
      mem_enable_reg <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      mem_id_reg     <= '0;
      err_reg        <= 1'b0;
    end else begin
      mem_enable_reg <= grant_any;
      if (grant_any) begin
        rr_ptr_reg    <= ID_WIDTH'(rr_next(grant_idx, N_REQ));
        mem_write_reg <= sel_req.write;
        mem_addr_reg  <= PA_WIDTH'(sel_req.addr);
        mem_data_reg  <= LINE_WIDTH'(sel_req.data);
        mem_id_reg    <= ID_WIDTH'(grant_idx);
      end
      // Unknown tag or a requester not waiting: drop it and flag.
      if (i_mem_enable && !(|resp_hit)) err_reg <= 1'b1;
    end
  end

  assign o_mem_enable = mem_enable_reg;
  assign o_mem_write  = mem_write_reg;
  assign o_mem_addr   = mem_addr_reg;
  assign o_mem_data   = mem_data_reg;
  assign o_mem_id     = mem_id_reg;
  assign o_resp_valid = resp_hit;
  assign o_resp_data  = i_mem_data;
  assign o_err        = err_reg;

endmodule
